// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl_pkg
// Purpose  : Shared types and constants for the seven-segment scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package display_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } scan_state_t;

   localparam int          NUM_DIGITS   = 4;
   localparam logic [3:0]  ANODE_OFF    = 4'b1111;
   localparam logic [1:0]  IDX_TENS_SUM = 2'd1;
   localparam logic [1:0]  IDX_TENS_CNT = 2'd3;

   // A slot lights only if unmasked and not a suppressed leading zero.
   function automatic logic slot_visible(
      input logic [3:0] mask,
      input logic [1:0] idx,
      input logic       lzb_en,
      input logic [3:0] tens_sum,
      input logic [3:0] tens_cnt
   );
      logic lz;
      lz = lzb_en && (((idx == IDX_TENS_SUM) && (tens_sum == 4'd0)) ||
                      ((idx == IDX_TENS_CNT) && (tens_cnt == 4'd0)));
      return mask[idx] && !lz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_slot_timer
// Purpose  : Per-slot cycle counter flagging end of dead time and end of slot.
// Revision : 1.0 - initial release
// ============================================================================
module scan_slot_timer #(
   parameter int SCAN_DIV    = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic dead_done,
   output logic slot_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

   if ((SCAN_DIV < 4) || (SCAN_DIV > (1 << 20))) begin : g_bad_scan_div
      $fatal(1, "scan_slot_timer: SCAN_DIV out of range 4..2^20");
   end
   if ((DEAD_CYCLES < 1) || (DEAD_CYCLES > SCAN_DIV - 2)) begin : g_bad_dead
      $fatal(1, "scan_slot_timer: DEAD_CYCLES out of range 1..SCAN_DIV-2");
   end

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = clear ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign dead_done = (count_q == DEAD_LAST);
   assign slot_done = (count_q == SLOT_LAST);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : 4-digit display scan sequencer with dead-time blanking, masking
//            and leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] digit_mask,
   input  logic       lzb_en,
   input  logic [3:0] tens_sum,
   input  logic [3:0] tens_cnt,
   output logic [1:0] refreshcounter,
   output logic [3:0] anodes,
   output logic       slot_tick,
   output logic       frame_tick
);

   scan_state_t           state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic                  show_q, show_d;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic                  slot_tick_q, slot_tick_d;
   logic                  frame_tick_q, frame_tick_d;
   logic                  w_tmr_clear;
   logic                  w_dead_done;
   logic                  w_slot_done;

   scan_slot_timer #(
      .SCAN_DIV    (SCAN_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (w_tmr_clear),
      .dead_done (w_dead_done),
      .slot_done (w_slot_done)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      show_d       = show_q;
      slot_tick_d  = 1'b0;
      frame_tick_d = 1'b0;
      w_tmr_clear  = 1'b0;

      // Disable overrides everything, including a coincident slot end.
      if (!enable) begin
         state_d     = ST_IDLE;
         w_tmr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_BLANK;
               w_tmr_clear = 1'b1;
            end
            ST_BLANK: begin
               if (w_dead_done) begin
                  state_d = ST_ON;
                  show_d  = slot_visible(digit_mask, idx_q, lzb_en, tens_sum, tens_cnt);
               end
            end
            ST_ON: begin
               if (w_slot_done) begin
                  state_d      = ST_BLANK;
                  idx_d        = idx_q + 2'd1;
                  slot_tick_d  = 1'b1;
                  frame_tick_d = (idx_q == 2'd3);
                  w_tmr_clear  = 1'b1;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               w_tmr_clear = 1'b1;
            end
         endcase
      end

      // Anodes are decoded from the next state so they change with it.
      anodes_d = ((state_d == ST_ON) && show_d) ? ~(4'b0001 << idx_d) : ANODE_OFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         show_q       <= 1'b0;
         anodes_q     <= ANODE_OFF;
         slot_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         show_q       <= show_d;
         anodes_q     <= anodes_d;
         slot_tick_q  <= slot_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign refreshcounter = idx_q;
   assign anodes         = anodes_q;
   assign slot_tick      = slot_tick_q;
   assign frame_tick     = frame_tick_q;

   a_dark_unless_on : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != ST_ON) |-> (anodes_q == ANODE_OFF));
   a_one_anode_max : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(~anodes_q));

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Scoreboard bench for display_scan_ctrl against a slot-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

   localparam int SCAN_DIV    = 8;
   localparam int DEAD_CYCLES = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] digit_mask;
   logic       lzb_en;
   logic [3:0] tens_sum;
   logic [3:0] tens_cnt;
   logic [1:0] refreshcounter;
   logic [3:0] anodes;
   logic       slot_tick;
   logic       frame_tick;

   display_scan_ctrl #(
      .SCAN_DIV    (SCAN_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .digit_mask     (digit_mask),
      .lzb_en         (lzb_en),
      .tens_sum       (tens_sum),
      .tens_cnt       (tens_cnt),
      .refreshcounter (refreshcounter),
      .anodes         (anodes),
      .slot_tick      (slot_tick),
      .frame_tick     (frame_tick)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: a slot is a timeline of SCAN_DIV cycles; position 0..DEAD-1
   // is dark, the rest lit if the digit was visible when lighting began.
   logic [7:0] exp_q[$];
   bit         m_running = 0;
   int         m_idx     = 0;
   int         m_pos     = 0;
   bit         m_show    = 0;

   always @(posedge clk) begin
      bit       st, ft, lit;
      logic [3:0] an;
      st = 0; ft = 0;
      if (!rst_n) begin
         m_running = 0; m_idx = 0; m_pos = 0; m_show = 0;
      end else if (!enable) begin
         m_running = 0; m_pos = 0;
      end else if (!m_running) begin
         m_running = 1; m_pos = 0;
      end else begin
         if (m_pos == SCAN_DIV - 1) begin
            st = 1;
            ft = (m_idx == 3);
            m_idx = (m_idx + 1) % 4;
            m_pos = 0;
         end else begin
            m_pos = m_pos + 1;
         end
         if (m_pos == DEAD_CYCLES) begin
            m_show = digit_mask[m_idx] &&
                     !(lzb_en && ((m_idx == 1 && tens_sum == 0) ||
                                  (m_idx == 3 && tens_cnt == 0)));
         end
      end
      lit = m_running && (m_pos >= DEAD_CYCLES) && m_show;
      an  = lit ? ~(4'b0001 << m_idx) : 4'b1111;
      exp_q.push_back({an, 2'(m_idx), st, ft});
   end

   bit mon_on = 1;
   always @(posedge clk) begin
      logic [7:0] e, a;
      #1;
      if (mon_on) begin
         a = {anodes, refreshcounter, slot_tick, frame_tick};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0t got an=%b rc=%0d st=%b ft=%b required an entry",
                     $time, a[7:4], a[3:2], a[1], a[0]);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               bad++;
               $display("FAIL cycle t=%0t got an=%b rc=%0d st=%b ft=%b required an=%b rc=%0d st=%b ft=%b",
                        $time, a[7:4], a[3:2], a[1], a[0], e[7:4], e[3:2], e[1], e[0]);
            end
         end
      end
   end

   task automatic wait_slot(input int t_idx, input int t_pos);
      int n = 0;
      while (!(m_running && m_idx == t_idx && m_pos == t_pos) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL wait_slot_timeout got idx=%0d pos=%0d required idx=%0d pos=%0d",
                  m_idx, m_pos, t_idx, t_pos);
      end
   endtask

   initial begin
      rst_n = 0; enable = 0; digit_mask = 4'b1111; lzb_en = 0;
      tens_sum = 4'd1; tens_cnt = 4'd1;
      repeat (3) @(negedge clk);
      rst_n = 1;

      // Steady scan, all digits.
      enable = 1;
      repeat (80) @(negedge clk);

      // Leading-zero blanking on slot 1, then a non-zero tens digit.
      lzb_en = 1; tens_sum = 4'd0; tens_cnt = 4'd5;
      repeat (40) @(negedge clk);
      tens_sum = 4'd3;
      repeat (40) @(negedge clk);

      // Mask out slots 1 and 3.
      lzb_en = 0; digit_mask = 4'b0101;
      repeat (40) @(negedge clk);
      digit_mask = 4'b1111;

      // Enable drop in the middle of slot 2's lit phase.
      wait_slot(2, DEAD_CYCLES + 2);
      enable = 0;
      repeat (3) @(negedge clk);
      enable = 1;
      repeat (20) @(negedge clk);

      // Asynchronous reset between clock edges during a lit slot.
      wait_slot(1, DEAD_CYCLES + 1);
      #2 rst_n = 0;
      #1;
      total++;
      if (anodes !== 4'b1111 || refreshcounter !== 2'd0) begin
         bad++;
         $display("FAIL async_reset got an=%b rc=%0d required an=1111 rc=0",
                  anodes, refreshcounter);
      end
      @(negedge clk);
      rst_n = 1;
      repeat (20) @(negedge clk);

      // Enable falls exactly as slot 3 ends.
      wait_slot(3, SCAN_DIV - 1);
      enable = 0;
      @(negedge clk);
      enable = 1;
      repeat (20) @(negedge clk);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         enable = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 29) == 0) digit_mask = 4'($urandom);
         if ($urandom_range(0, 29) == 0) lzb_en = 1'($urandom);
         if ($urandom_range(0, 9) == 0)
            tens_sum = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
         if ($urandom_range(0, 9) == 0)
            tens_cnt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
         @(negedge clk);
      end

      @(posedge clk);
      #2;
      mon_on = 0;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequencer for the shared 4-digit seven-segment display multiplexer. Generates the 2-bit digit-select index that steers the mux, and drives the active-low anode lines with a dead-time blank around every index change to prevent ghosting. Also applies per-digit masking and leading-zero blanking of the tens digits of the adder result and the counter. Sits between the system clock and the display mux/pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (blank plus on-time); legal range 4..2^20.
DEAD_CYCLES, 500, cycles per slot with all anodes off after an index change; legal range 1..SCAN_DIV-2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning runs; 0 = display dark, index frozen
digit_mask  in  4  per-slot enable, bit i = slot i; 0 keeps the anode off for that slot
lzb_en  in  1  leading-zero blanking enable for slots 1 and 3
tens_sum  in  4  BCD value shown in slot 1 (adder tens)
tens_cnt  in  4  BCD value shown in slot 3 (counter tens)
refreshcounter  out  2  digit-select index to the display mux
anodes  out  4  active-low one-hot anode drive, bit i = slot i
slot_tick  out  1  one-cycle pulse on each index advance
frame_tick  out  1  one-cycle pulse when the index wraps 3 -> 0

Behaviour:
- One clock domain (clk). rst_n is asynchronous and active-low: assertion acts immediately; deassertion is used synchronously.
- Reset values: refreshcounter=0, anodes=4'b1111, slot_tick=0, frame_tick=0, FSM=IDLE, slot counter=0.
- FSM states: IDLE, BLANK, ON.
  - IDLE: anodes=1111. If enable=1, go to BLANK and load the counter with 0. The index is not advanced on this entry.
  - BLANK: anodes=1111. The counter increments each cycle. When it reaches DEAD_CYCLES-1, go to ON.
  - On the BLANK->ON transition, latch show = digit_mask[idx] AND NOT (lzb_en AND ((idx==1 AND tens_sum==0) OR (idx==3 AND tens_cnt==0))).
  - ON: anodes = ~(show << idx), i.e. active-low one-hot, or 1111 when show=0. The counter keeps incrementing.
  - ON exit: when the counter reaches SCAN_DIV-1, advance idx = idx+1 (mod 4, 3 wraps to 0), pulse slot_tick for one cycle, pulse frame_tick if the old idx was 3, clear the counter and go to BLANK.
- The index changes only on ON->BLANK, so the mux output settles while anodes are dark. refreshcounter equals idx and is registered.
- Slot timing:
  - Every slot lasts exactly SCAN_DIV cycles (DEAD_CYCLES dark plus SCAN_DIV-DEAD_CYCLES lit).
  - Masked and blanked slots keep their full duration, so brightness stays constant.
  - Frame period = 4*SCAN_DIV cycles.
- Input sampling:
  - mask and LZB inputs are sampled once per slot, on BLANK->ON.
  - Changes during ON take effect in the next visit to that slot.
- enable=0 in any state: next cycle FSM=IDLE, anodes=1111, counter=0, idx held, no ticks.
  - Re-enable restarts the same idx with a full BLANK.
- Simultaneous enable fall and slot end: enable wins. No advance, no ticks.
- Counter width: clog2(SCAN_DIV). Out-of-range parameters are a fatal elaboration error.
- At most one anode is ever low. anodes is never low in IDLE or BLANK (verification assertion).

Decomposition:
- Shared package holds the FSM state encoding (IDLE/BLANK/ON), NUM_DIGITS=4, ANODE_OFF=4'b1111, and the slot-index constants for tens_sum (1) and tens_cnt (3).
- One sub-module: scan_slot_timer, a parameterised counter that raises dead_done at DEAD_CYCLES-1 and slot_done at SCAN_DIV-1, with a synchronous clear.
- FSM, index register and anode decode stay in the top module.

Test Plan:
- Reset and steady scan (SCAN_DIV=8, DEAD_CYCLES=2, mask=1111, lzb_en=0, enable=1) -> anode sequence 1110, 1101, 1011, 0111. Each anode is low 6 cycles, preceded by 2 cycles of 1111. frame_tick fires every 32 cycles. refreshcounter changes only in cycles with anodes=1111.
- Leading-zero blanking (lzb_en=1, tens_sum=0, tens_cnt=5) -> slot 1 stays at 1111 for its full 8 cycles. Slot 3 lights as 0111. Slot timing is unchanged. Repeating with tens_sum=3 lights slot 1 as 1101.
- Mask (digit_mask=0101) -> only 1110 and 1011 appear. slot_tick still pulses every 8 cycles.
- Enable drop mid-ON on slot 2 -> anodes=1111 next cycle, refreshcounter holds 2, no ticks. Re-enable -> 2 cycles of 1111, then 1011 lit for 6 cycles.
- Async reset asserted mid-ON, between clock edges -> anodes=1111 and refreshcounter=0 immediately, before the next edge. After deassertion, scanning restarts from slot 0 with a full BLANK.
- Simultaneous enable fall and slot_done at idx=3 -> no frame_tick, idx stays 3.
